// File: rtl/cm_pkg.sv
// Shared types and constants for the image-buffer control sequencer.
package cm_pkg;

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

   localparam int RD_DEPTH_DEF   = 512;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/cm_counter.sv
// Up-counter with enable, synchronous clear and terminal-count flag.
// It wraps to zero on the cycle after it reaches MAX.
module cm_counter #(
   parameter int W   = 8,
   parameter int MAX = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_d, cnt_q;

   assign cnt = cnt_q;
   assign tc  = (cnt_q == W'(MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cm_sequencer.sv
// Write-then-read pass sequencer for the two image BRAMs; all outputs registered.
// Define CM_ADDR_OUT_EN to expose the byte/word counters as wr_addr / rd_addr.
module cm_sequencer
   import cm_pkg::*;
#(
   parameter int RD_DEPTH = RD_DEPTH_DEF,
   parameter int RD_AW    = 9,
   parameter int WR_AW    = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ena,
   output logic             wea1,
   output logic             wea2,
   output logic             enb,
   output logic [1:0]       sel,
   output logic             complete
`ifdef CM_ADDR_OUT_EN
  ,output logic [WR_AW-1:0] wr_addr,
   output logic [RD_AW-1:0] rd_addr
`endif
);

   // Read counter counts bytes; the upper bits form the word index.
   localparam int RC_W = RD_AW + 2;
   localparam int LAST = BYTES_PER_WORD * RD_DEPTH - 1;

   state_e          state_d, state_q;
   logic            ena_d, ena_q;
   logic            we_d, we_q;
   logic            enb_d, enb_q;
   logic            complete_d, complete_q;
   logic [1:0]      sel_d, sel_q;
   logic [WR_AW-1:0] wr_cnt;
   logic [RC_W-1:0]  rd_cnt;
   logic            wr_tc, rd_tc;

   cm_counter #(.W(WR_AW), .MAX(LAST)) u_wr_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (state_q == WRITE),
      .clr   (state_q == IDLE),
      .cnt   (wr_cnt),
      .tc    (wr_tc)
   );

   cm_counter #(.W(RC_W), .MAX(LAST)) u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (state_q == READ),
      .clr   (state_q == IDLE),
      .cnt   (rd_cnt),
      .tc    (rd_tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = WRITE;
         WRITE:   if (wr_tc) state_d = READ;
         READ:    if (rd_tc) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs follow the next state so they line up with it after the edge.
      ena_d      = (state_d == WRITE);
      we_d       = (state_d == WRITE);
      enb_d      = (state_d == READ);
      complete_d = (state_d == DONE);
      // Byte select trails the read address by the BRAM's one-cycle latency.
      sel_d      = (state_d == READ || state_d == DRAIN) ? rd_cnt[1:0] : 2'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ena_q      <= 1'b0;
         we_q       <= 1'b0;
         enb_q      <= 1'b0;
         complete_q <= 1'b0;
         sel_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         ena_q      <= ena_d;
         we_q       <= we_d;
         enb_q      <= enb_d;
         complete_q <= complete_d;
         sel_q      <= sel_d;
      end
   end

   assign ena      = ena_q;
   assign wea1     = we_q;
   assign wea2     = we_q;
   assign enb      = enb_q;
   assign complete = complete_q;
   assign sel      = sel_q;

`ifdef CM_ADDR_OUT_EN
   // Both counters wrap to zero at the end of their phase, so they read 0 outside it.
   assign wr_addr = wr_cnt;
   assign rd_addr = rd_cnt[RC_W-1:2];
`else
   logic unused_cnt;
   assign unused_cnt = ^{wr_cnt, rd_cnt[RC_W-1:2]};
`endif

endmodule

// File: tb/tb_cm_sequencer.sv
// Directed bench for cm_sequencer with RD_DEPTH=2 (8 write, 8 read, 1 drain cycle).
module tb_cm_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       ena, wea1, wea2, enb, complete;
   logic [1:0] sel;
`ifdef CM_ADDR_OUT_EN
   logic [2:0] wr_addr;
   logic [0:0] rd_addr;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cm_sequencer #(.RD_DEPTH(2), .RD_AW(1), .WR_AW(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .ena      (ena),
      .wea1     (wea1),
      .wea2     (wea2),
      .enb      (enb),
      .sel      (sel),
      .complete (complete)
`ifdef CM_ADDR_OUT_EN
     ,.wr_addr  (wr_addr),
      .rd_addr  (rd_addr)
`endif
   );

   // {ena, wea1, wea2, enb, complete, sel}
   logic [6:0] outs;
   assign outs = {ena, wea1, wea2, enb, complete, sel};

   localparam logic [6:0] O_IDLE  = 7'b000_0_0_00;
   localparam logic [6:0] O_WRITE = 7'b111_0_0_00;
   localparam logic [6:0] O_DONE  = 7'b000_0_1_00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_addr(input string tag, input int wa, input int ra);
`ifdef CM_ADDR_OUT_EN
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(wa));
      chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(ra));
`endif
   endtask

   // Entered in the first WRITE cycle; returns in the first DONE cycle.
   task automatic check_pass(input string tag);
      logic [1:0] s;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_write"}, 32'(outs), 32'(O_WRITE));
         chk_addr({tag, "_write"}, i, 0);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         s = (k == 0) ? 2'd0 : 2'(k - 1);
         chk({tag, "_read"}, 32'(outs), 32'({5'b000_1_0, s}));
         chk_addr({tag, "_read"}, 0, k / 4);
         tick();
      end
      chk({tag, "_drain"}, 32'(outs), 32'(7'b000_0_0_11));
      tick();
      chk({tag, "_done"}, 32'(outs), 32'(O_DONE));
      chk_addr({tag, "_done"}, 0, 0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b1;
      #3;
      chk("rst_async", 32'(outs), 32'(O_IDLE));
      chk_addr("rst_async", 0, 0);
      tick();
      chk("rst_held", 32'(outs), 32'(O_IDLE));
      reset = 1'b1;
      tick();
      check_pass("pass1");

      // DONE holds while start stays high.
      tick();
      chk("done_hold1", 32'(outs), 32'(O_DONE));
      tick();
      chk("done_hold2", 32'(outs), 32'(O_DONE));

      // Restart: drop start, back to IDLE, then a second identical pass.
      start = 1'b0;
      tick();
      chk("restart_idle", 32'(outs), 32'(O_IDLE));
      chk_addr("restart_idle", 0, 0);
      start = 1'b1;
      tick();
      check_pass("pass2");

      // One-cycle start pulse still runs the whole pass; DONE exits at once.
      start = 1'b0;
      tick();
      chk("glitch_idle_pre", 32'(outs), 32'(O_IDLE));
      start = 1'b1;
      tick();
      start = 1'b0;
      check_pass("glitch");
      tick();
      chk("glitch_done_exit", 32'(outs), 32'(O_IDLE));
      tick();
      chk("glitch_idle_stay", 32'(outs), 32'(O_IDLE));

      // Mid-pass reset on the 5th READ cycle.
      start = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) tick();
      chk("mid_read5", 32'(outs), 32'(7'b000_1_0_11));
      reset = 1'b0;
      #1;
      chk("mid_rst_async", 32'(outs), 32'(O_IDLE));
      chk_addr("mid_rst_async", 0, 0);
      tick();
      chk("mid_rst_held", 32'(outs), 32'(O_IDLE));
      reset = 1'b1;
      tick();
      check_pass("post_rst");

      start = 1'b0;
      tick();
      chk("final_idle", 32'(outs), 32'(O_IDLE));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
